// File: rtl/nes_pad_serializer.sv
// -----------------------------------------------------------------------------
// nes_pad_serializer
//
// Emulates the 4021 shift register inside an NES controller. The console's
// asynchronous latch and shift-clock lines are synchronized into the USB host
// clock domain and glitch-filtered. The 8-bit button vector is then presented
// on the active-low serial data line in the order
// A, B, Select, Start, Up, Down, Left, Right.
//
// Parameters
//   FILT_LEN  : consecutive identical synced samples needed to change a
//               filtered level (1..15)
//   SOCD_MASK : 1 = opposing directions pressed together read as released
//   TURBO_DIV : frames per turbo phase toggle (1..255), turbo builds only
//
// Optional feature
//   NES_PAD_TURBO_EN : when defined, turbo_a / turbo_b replace A / B with a
//                      phase that toggles every TURBO_DIV frames.
//
// Ports
//   clk          in   block clock (USB host clock)
//   nreset       in   asynchronous active-low reset
//   pad_in[7:0]  in   buttons, active-high: R,L,D,U,Start,Select,B,A
//   nes_latch    in   console latch/strobe (asynchronous)
//   nes_clk      in   console shift clock (asynchronous)
//   turbo_a      in   auto-fire request for A (unused without the macro)
//   turbo_b      in   auto-fire request for B (unused without the macro)
//   nes_data     out  serial data to console, low = pressed (registered)
//   frame_strobe out  one-cycle pulse per filtered latch falling edge
//   bit_cnt[3:0] out  bits shifted since the last latch, saturates at 8
// -----------------------------------------------------------------------------
module nes_pad_serializer #(
  parameter int unsigned FILT_LEN  = 2,
  parameter bit          SOCD_MASK = 1'b1,
  parameter int unsigned TURBO_DIV = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] pad_in,
  input  logic       nes_latch,
  input  logic       nes_clk,
  input  logic       turbo_a,
  input  logic       turbo_b,
  output logic       nes_data,
  output logic       frame_strobe,
  output logic [3:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  // Index 0 = latch line, index 1 = clock line.
  logic [1:0]      sync_meta;
  logic [1:0]      sync_q;
  logic [1:0]      filt;
  logic [1:0]      filt_q;
  logic [1:0][3:0] filt_cnt;

  logic            latch_rise;
  logic            latch_fall;
  logic            clk_rise;

  state_t          state;
  state_t          state_next;
  logic            load_en;
  logic            shift_en;
  logic            strobe_next;

  logic [7:0]      shreg;
  logic [7:0]      pad_eff;
  logic            phase;

  // ---------------------------------------------------------------------------
  // Synchronizers and glitch filters for both console lines.
  // ---------------------------------------------------------------------------
  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, like the real hardware.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_meta <= '0;
      sync_q    <= '0;
      filt      <= '0;
      filt_q    <= '0;
      filt_cnt  <= '0;
    end else begin
      sync_meta <= {nes_clk, nes_latch};
      sync_q    <= sync_meta;
      filt_q    <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          // FILT_LEN-th disagreeing sample in a row: accept the new level.
          filt[i]     <= ~filt[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign latch_rise =  filt[0] & ~filt_q[0];
  assign latch_fall = ~filt[0] &  filt_q[0];
  assign clk_rise   =  filt[1] & ~filt_q[1];

  // ---------------------------------------------------------------------------
  // Optional turbo phase generator.
  // ---------------------------------------------------------------------------
`ifdef NES_PAD_TURBO_EN
  localparam logic [7:0] TURBO_LAST = 8'(TURBO_DIV - 1);

  logic [7:0] frame_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_strobe) begin
      if (frame_cnt == TURBO_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  // Turbo inputs are intentionally ignored in this build.
  logic unused_turbo;
  assign unused_turbo = turbo_a ^ turbo_b;
  assign phase        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Effective button vector: SOCD cleaning plus optional turbo override.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pad_eff = pad_in;
    if (SOCD_MASK) begin
      if (pad_in[4] && pad_in[5]) pad_eff[5:4] = 2'b00;
      if (pad_in[6] && pad_in[7]) pad_eff[7:6] = 2'b00;
    end
`ifdef NES_PAD_TURBO_EN
    pad_eff[0] = turbo_a ? phase : pad_in[0];
    pad_eff[1] = turbo_b ? phase : pad_in[1];
`endif
  end

  // ---------------------------------------------------------------------------
  // Read-cycle state machine.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    strobe_next = 1'b0;
    // Latch has priority: a rise reloads even if a clock rise coincides.
    load_en     = latch_rise || ((state == LOAD) && filt[0]);
    shift_en    = (state == SHIFT) && clk_rise && !latch_rise;
    case (state)
      IDLE: begin
        if (latch_rise) state_next = LOAD;
      end
      LOAD: begin
        if (latch_fall) begin
          strobe_next = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (latch_rise) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register, bit counter and frame strobe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg        <= 8'hFF;
      bit_cnt      <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= strobe_next;
      if (load_en) begin
        shreg   <= ~pad_eff;
        bit_cnt <= '0;
      end else if (shift_en) begin
        // Zero fill: after eight shifts the line reads "pressed" like a 4021
        // with its serial input tied low.
        shreg <= {1'b0, shreg[7:1]};
        if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign nes_data = shreg[0];

endmodule

// File: tb/tb_nes_pad_serializer.sv
// -----------------------------------------------------------------------------
// tb_nes_pad_serializer
//
// Drives console-style read cycles into two instances (SOCD masking on and
// off) and compares every serial bit, the bit counter and the frame strobe
// with a frame-level reference model: at each latch the model forms the
// button snapshot from the button rules and expects the console to read its
// inverted bits in order, then zeros.
// -----------------------------------------------------------------------------
module tb_nes_pad_serializer;

  localparam int FL  = 2;  // FILT_LEN of both instances
  localparam int TDV = 2;  // TURBO_DIV of both instances

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] pad_in;
  logic       nes_latch;
  logic       nes_clk;
  logic       turbo_a;
  logic       turbo_b;
  logic       data_m, data_n;
  logic       strobe_m, strobe_n;
  logic [3:0] cnt_m, cnt_n;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int frames = 0;      // model: frame strobes since reset
  logic last_a;

  always #5 clk = ~clk;

  nes_pad_serializer #(.FILT_LEN(FL), .SOCD_MASK(1'b1), .TURBO_DIV(TDV)) dut_m (
    .clk(clk), .nreset(nreset), .pad_in(pad_in), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .turbo_a(turbo_a), .turbo_b(turbo_b),
    .nes_data(data_m), .frame_strobe(strobe_m), .bit_cnt(cnt_m));

  nes_pad_serializer #(.FILT_LEN(FL), .SOCD_MASK(1'b0), .TURBO_DIV(TDV)) dut_n (
    .clk(clk), .nreset(nreset), .pad_in(pad_in), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .turbo_a(turbo_a), .turbo_b(turbo_b),
    .nes_data(data_n), .frame_strobe(strobe_n), .bit_cnt(cnt_n));

  // Reads the pre-edge strobe value, so each high cycle counts exactly once.
  always @(posedge clk) if (strobe_m === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button rules: opposing directions cancel when masking, turbo replaces A/B.
  function automatic logic [7:0] eff(input logic [7:0] p, input bit mask,
                                     input bit ta, input bit tb, input bit ph);
    logic [7:0] e;
    e = p;
    if (mask && p[4] && p[5]) begin e[4] = 1'b0; e[5] = 1'b0; end
    if (mask && p[6] && p[7]) begin e[6] = 1'b0; e[7] = 1'b0; end
`ifdef NES_PAD_TURBO_EN
    if (ta) e[0] = ph;
    if (tb) e[1] = ph;
`else
    if (ta && tb) e = e;  // turbo has no effect in this build
`endif
    return e;
  endfunction

  // One console read: latch pulse (pad p0 then p1 while high), nclk clocks,
  // pad changed to p2 after the first clock, optional glitches.
  task automatic do_frame(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input int nclk,
                          input bit glitch, input bit ta, input bit tb);
    logic [7:0] sm, sn;
    logic       em, en, hold_d;
    int         s0, exp_cnt;
    bit         ph;
    turbo_a = ta; turbo_b = tb;
    pad_in = p0; nes_latch = 1'b1;
    cyc(3);
    pad_in = p1;
    cyc(FL + 8);
    ph = ((frames / TDV) % 2) != 0;
    sm = ~eff(p1, 1'b1, ta, tb, ph);
    sn = ~eff(p1, 1'b0, ta, tb, ph);
    check("latch_data_m", data_m, sm[0]);
    check("latch_data_n", data_n, sn[0]);
    check("latch_cnt", cnt_m, 0);
    last_a = data_m;
    s0 = strobe_cnt;
    nes_latch = 1'b0;
    cyc(FL + 6);
    check("strobe_once", strobe_cnt - s0, 1);
    frames++;
    exp_cnt = 0;
    for (int i = 0; i < nclk; i++) begin
      if (i == 1) pad_in = p2;
      em = (i < 8) ? sm[i[2:0]] : 1'b0;
      en = (i < 8) ? sn[i[2:0]] : 1'b0;
      check("bit_m", data_m, em);
      check("bit_n", data_n, en);
      check("cnt", cnt_m, exp_cnt);
      nes_clk = 1'b0;
      cyc(FL + 5);
      if (glitch && i == 2) begin
        nes_clk = 1'b1; cyc(1); nes_clk = 1'b0;
        cyc(FL + 5);
        check("clk_glitch_cnt", cnt_m, exp_cnt);
        check("clk_glitch_data", data_m, em);
      end
      nes_clk = 1'b1;
      cyc(FL + 2);
      check("lat_before", cnt_m, exp_cnt);
      exp_cnt = (exp_cnt < 8) ? exp_cnt + 1 : 8;
      cyc(1);
      check("lat_after", cnt_m, exp_cnt);
      cyc(FL + 3);
    end
    em = (nclk < 8) ? sm[nclk[2:0]] : 1'b0;
    check("end_data", data_m, em);
    check("end_cnt", cnt_m, exp_cnt);
    if (glitch) begin
      hold_d = data_m;
      s0 = strobe_cnt;
      nes_latch = 1'b1; cyc(1); nes_latch = 1'b0;
      cyc(FL + 6);
      check("latch_glitch_strobe", strobe_cnt - s0, 0);
      check("latch_glitch_cnt", cnt_m, exp_cnt);
      check("latch_glitch_data", data_m, hold_d);
    end
  endtask

  initial begin
    logic [7:0] a, b;
    nreset = 1'b0; nes_latch = 1'b0; nes_clk = 1'b1;
    pad_in = 8'h00; turbo_a = 1'b0; turbo_b = 1'b0;
    cyc(3);
    check("rst_data", data_m, 1);
    check("rst_cnt", cnt_m, 0);
    check("rst_strobe", strobe_m, 0);
    nreset = 1'b1;
    cyc(20);
    check("idle_data", data_m, 1);
    check("idle_cnt", cnt_m, 0);
    check("idle_strobe_cnt", strobe_cnt, 0);

    // Directed: R+A, snapshot hold, U+D, L+R with glitches, overread.
    do_frame(8'h81, 8'h81, 8'h81, 8, 1'b0, 1'b0, 1'b0);
    do_frame(8'h01, 8'h01, 8'h02, 8, 1'b0, 1'b0, 1'b0);
    do_frame(8'h02, 8'h02, 8'h02, 8, 1'b0, 1'b0, 1'b0);
    do_frame(8'h30, 8'h30, 8'h00, 8, 1'b0, 1'b0, 1'b0);
    do_frame(8'hC5, 8'hC5, 8'h00, 10, 1'b1, 1'b0, 1'b0);

    // Random frames, including mid-latch pad changes.
    for (int k = 0; k < 14; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(1) != 0) ? 8'($urandom) : a;
      do_frame(a, b, 8'($urandom), 8 + int'($urandom_range(2)),
               ($urandom_range(3) == 0), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a read, then clocks without a latch.
    pad_in = 8'h00; turbo_a = 1'b0; turbo_b = 1'b0;
    nes_latch = 1'b1; cyc(FL + 8);
    nes_latch = 1'b0; cyc(FL + 6);
    for (int i = 0; i < 3; i++) begin
      nes_clk = 1'b0; cyc(FL + 5); nes_clk = 1'b1; cyc(FL + 5);
    end
    check("pre_rst_cnt", cnt_m, 3);
    nes_clk = 1'b0; cyc(2);
    nreset = 1'b0; #1;
    check("mid_rst_data", data_m, 1);
    check("mid_rst_cnt", cnt_m, 0);
    check("mid_rst_strobe", strobe_m, 0);
    frames = 0;
    cyc(2);
    nreset = 1'b1;
    nes_clk = 1'b1; cyc(FL + 6);
    nes_clk = 1'b0; cyc(FL + 5); nes_clk = 1'b1; cyc(FL + 5);
    check("post_rst_cnt", cnt_m, 0);
    check("post_rst_data", data_m, 1);

`ifdef NES_PAD_TURBO_EN
    begin
      logic [7:0] tur_exp;
      tur_exp = 8'h33;  // A reads released,released,pressed,pressed,...
      for (int k = 0; k < 8; k++) begin
        do_frame(8'h00, 8'h00, 8'h00, 8, 1'b0, 1'b1, 1'b0);
        check("turbo_a", last_a, tur_exp[k]);
      end
    end
`endif

    // Normal operation resumes after reset.
    do_frame(8'h81, 8'h81, 8'h00, 8, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_serializer.md
Name: nes_pad_serializer

Overview:
- Downstream consumer of the 8-bit NES button vector built from the USB HID report. Emulates an NES controller's 4021 shift register toward a real console or NES core.
- Samples the console's asynchronous latch/clock lines in the USB clock domain (6 MHz LS / 12 MHz FS) and drives the active-low serial data line.
- Bit order is A, B, Select, Start, Up, Down, Left, Right.

Parameters:
- FILT_LEN, 2: consecutive identical synchronized samples needed before a filtered latch/clk level changes (1..15).
- SOCD_MASK, 1: when 1, opposing directions pressed together (U+D or L+R) are both reported released.
- TURBO_DIV, 2: frames per turbo phase toggle (1..255). Used only with NES_PAD_TURBO_EN.

Ports:
- clk, input, 1: block clock, same as the USB host clock.
- nreset, input, 1: asynchronous, active-low reset.
- pad_in, input, 8: button state, active-high pressed. [7:0] = R,L,D,U,Start,Select,B,A. Synchronous to clk.
- nes_latch, input, 1: console latch/strobe. Asynchronous.
- nes_clk, input, 1: console shift clock. Asynchronous.
- turbo_a, input, 1: auto-fire request for A. Ignored without macro.
- turbo_b, input, 1: auto-fire request for B. Ignored without macro.
- nes_data, output, 1: serial data to console, low = pressed.
- frame_strobe, output, 1: one-cycle pulse on each filtered latch falling edge.
- bit_cnt, output, 4: bits shifted since last latch, saturates at 8.

Behaviour:
- Reset values (clock and reset ports are clk and nreset; reset is asynchronous, active-low):
  - shreg = 8'hFF, so nes_data = 1.
  - bit_cnt = 0, frame_strobe = 0.
  - Filtered latch/clk = 0, filter counters = 0, turbo phase = 0, state = IDLE.
- Synchronizers: nes_latch and nes_clk each pass through a 2-FF synchronizer.
- Glitch filter: the filtered level flips only after FILT_LEN consecutive synced samples differ from it. Any agreeing sample clears the counter.
- Edge detect: 1-cycle pulses for latch rise, latch fall and clk rise, taken from the filtered levels.
- Effective pad value pad_eff = pad_in:
  - With SOCD_MASK=1: bits 4 and 5 are forced 0 when both set; bits 6 and 7 likewise.
  - Turbo override applies only with the macro (see Optional Feature).
- State machine:
  - IDLE: the shift register holds its value. Latch rise goes to LOAD.
  - LOAD: while filtered latch = 1, shreg <= ~pad_eff every cycle (transparent reload) and bit_cnt <= 0. Clock rises are ignored. Latch fall asserts frame_strobe for one cycle and goes to SHIFT.
  - SHIFT: on a clk rise, shreg <= {1'b0, shreg[7:1]} and bit_cnt <= min(bit_cnt+1, 8). Latch rise goes to LOAD.
- nes_data = shreg[0], registered, no combinational path from the inputs.
- After 8 shifts nes_data = 0, matching an official pad (console reads 1). Further clocks keep it 0; bit_cnt stays at 8.
- Latch rise and clk rise in the same cycle: latch wins, load happens, no shift.
- pad_in changes during SHIFT have no effect until the next LOAD (snapshot is held).
- Latency: a nes_latch or nes_clk pin edge affects nes_data within 2 + FILT_LEN + 1 clk cycles.
- nreset asserted mid-read: immediate return to reset values. After release, the block waits in IDLE for the next latch rise.

Optional Feature:
- Macro NES_PAD_TURBO_EN.
- Defined:
  - An 8-bit frame counter counts frame_strobe pulses. The turbo phase toggles and the counter clears when the count reaches TURBO_DIV.
  - pad_eff[0] = turbo_a ? phase : pad_in[0]; pad_eff[1] = turbo_b ? phase : pad_in[1].
- Not defined: turbo_a and turbo_b are unused, no counter logic is generated, pad_eff[1:0] = pad_in[1:0].

Test Plan:
- Reset check: nreset=0 -> nes_data=1, bit_cnt=0, frame_strobe=0. Release, with no latch activity -> outputs unchanged.
- Basic read: pad_in=8'h81 (R+A), latch pulse 12 us, then 8 clk pulses (6 us low/high). Bits seen before each clock are 0,1,1,1,1,1,1,0. After 8 clocks nes_data=0, bit_cnt=8, frame_strobe pulsed once.
- Snapshot hold: pad_in=8'h01 at latch. Change to 8'h02 after the first clk -> second bit still reads 1 (B released). The next frame reflects 8'h02.
- Glitch rejection, FILT_LEN=2: a 1-cycle nes_clk glitch in SHIFT -> no shift, bit_cnt unchanged. A 1-cycle latch glitch -> no reload, no frame_strobe.
- SOCD: pad_in=8'h30 (U+D), SOCD_MASK=1 -> bits 5 and 6 of the read sequence are 1. With SOCD_MASK=0 -> both read 0.
- Turbo (macro on, TURBO_DIV=2): turbo_a=1, pad_in=0, 8 frames -> A reads released, released, pressed, pressed, released, released, pressed, pressed.
